predictor_eval_ctrl: RTL and testbench
======================================

Name: predictor_eval_ctrl

Overview:
Scheduler that stores a test bit-pattern and replays it, one bit per cycle, to two competing pattern predictors in lockstep. It clears the predictors before each run, scores each predictor's per-cycle prediction against the replayed actual bit, and reports match counts and a winner. It sits between the test/config interface and the predictor datapaths, replacing free-running ad-hoc match counters with one sequenced evaluation.

Parameters:
DEPTH, 64, pattern buffer capacity in bits; power of 2, >= 2.
CW, 8, width of match/total counters; saturating.
PW, $clog2(DEPTH)+1, pointer/length width (derived, not overridden).

Ports:
clk  input  1  clock, all state on rising edge.
reset  input  1  asynchronous, active-high reset.
clear_buf  input  1  empty the pattern buffer (write pointer to 0); honoured only in IDLE.
load_valid  input  1  write load_bit into the buffer this cycle.
load_bit  input  1  pattern bit to store.
load_ready  output  1  buffer accepts a write (IDLE and fill < DEPTH).
fill  output  PW  number of stored bits.
start  input  1  begin an evaluation run; honoured only in IDLE with post-write fill > 0.
busy  output  1  high in CLEAR, RUN and DONE.
pred_clr  output  1  one-cycle synchronous clear to both predictors.
act_valid  output  1  act_bit is a live pattern bit this cycle.
act_bit  output  1  replayed actual pattern bit.
pred_a  input  1  predictor A's prediction for the current act_bit (combinational from its state).
pred_b  input  1  predictor B's prediction, same timing.
cnt_a  output  CW  matches scored by A in the last or current run.
cnt_b  output  CW  matches scored by B.
total  output  CW  bits replayed in the last or current run.
winner  output  2  01 = A ahead, 10 = B ahead, 11 = tie, 00 = no result.
done  output  1  one-cycle pulse at end of run.

Behaviour:
- Reset (async): state IDLE; fill, read pointer, cnt_a, cnt_b, total, winner = 0; busy, pred_clr, act_valid, act_bit, done = 0. Buffer contents are don't-care.
- States: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - load_ready = (fill < DEPTH).
  - load_valid && load_ready writes buf[fill] and increments fill.
  - load_valid while full is dropped silently; fill is unchanged.
  - clear_buf sets fill to 0 and takes priority over a same-cycle load.
  - start goes to CLEAR if (fill + accepted write) > 0; otherwise start is ignored.
  - A bit written in the same cycle as start is included in the run.
- CLEAR (1 cycle):
  - pred_clr = 1.
  - cnt_a, cnt_b, total, winner zeroed at the end of the cycle.
  - Read pointer set to 0; next state RUN.
- RUN (exactly fill cycles):
  - act_valid = 1, act_bit = buf[rd].
  - Each cycle: cnt_a += (pred_a == act_bit), cnt_b += (pred_b == act_bit), total += 1; rd += 1.
  - Every counter saturates at 2^CW-1; no wrap.
  - When rd == fill-1, next state is DONE.
- DONE (1 cycle):
  - done = 1.
  - winner registered from final counts: A > B gives 01, B > A gives 10, equal gives 11. Comparison uses the saturated values.
  - Next state IDLE.
- Timing: start sampled at edge k gives pred_clr in cycle k+1, act_valid in cycles k+2 .. k+1+N, and done in cycle k+2+N (N = fill).
- Outside RUN, act_valid = 0 and act_bit = 0.
- In CLEAR, RUN and DONE: start, load_valid and clear_buf are ignored; load_ready = 0.
- Buffer and fill persist across runs, so back-to-back runs replay the same pattern.
- cnt_a, cnt_b, total and winner hold after DONE until the next CLEAR.
- Reset mid-run aborts immediately to the reset values; no done pulse is produced.

Test Plan:
1. DEPTH=64, CW=8; load 1,1,0,1,1,0,1,1; pred_a driven = act_bit, pred_b tied 0; start -> pred_clr 1 cycle; act_valid for 8 cycles with that bit sequence; done at k+10; cnt_a=8, cnt_b=2, total=8, winner=01.
2. Empty buffer, pulse start -> no pred_clr, busy stays 0, winner stays 00. Then start together with a single load_bit=1 -> 1-bit run, total=1.
3. Load 64 bits, then a 65th load_valid -> load_ready=0 at fill=64, 65th bit dropped; run gives total=64.
4. CW=4, DEPTH=32; load 20 bits, both predictors perfect -> cnt_a=cnt_b=total=15 (saturated), winner=11.
5. Assert reset during the 3rd RUN cycle -> act_valid, busy, counts and fill all 0 immediately; no done pulse. A subsequent start with an empty buffer is ignored.
6. Pulse start, clear_buf and load_valid during RUN -> all ignored; run completes normally. A second start after DONE replays the identical pattern with identical counts.

Source files
------------

// File: rtl/predictor_eval_if.sv
// Bundle between the predictor evaluation scheduler and its test/config
// side plus the two predictor datapaths.
//
// Load handshake: a pattern bit transfers on a rising clk edge where
// load_valid && load_ready are both high. load_valid may be raised at any
// time. A transfer does not take place while load_ready is low (full buffer
// or evaluation in progress), and that bit is dropped rather than held.
interface predictor_eval_if #(
    parameter int DEPTH = 64,
    parameter int CW    = 8,
    parameter int PW    = $clog2(DEPTH) + 1
);
    // config / test side
    logic          clear_buf;
    logic          load_valid;
    logic          load_bit;
    logic          load_ready;
    logic [PW-1:0] fill;
    logic          start;
    logic          busy;
    // predictor side
    logic          pred_clr;
    logic          act_valid;
    logic          act_bit;
    logic          pred_a;
    logic          pred_b;
    // results
    logic [CW-1:0] cnt_a;
    logic [CW-1:0] cnt_b;
    logic [CW-1:0] total;
    logic [1:0]    winner;
    logic          done;
    // debug: current scheduler state (0 idle, 1 clear, 2 run, 3 done)
    logic [1:0]    state_dbg;

    modport slave (
        input  clear_buf, load_valid, load_bit, start, pred_a, pred_b,
        output load_ready, fill, busy, pred_clr, act_valid, act_bit,
               cnt_a, cnt_b, total, winner, done, state_dbg
    );

    modport master (
        output clear_buf, load_valid, load_bit, start, pred_a, pred_b,
        input  load_ready, fill, busy, pred_clr, act_valid, act_bit,
               cnt_a, cnt_b, total, winner, done, state_dbg
    );
endinterface

// File: rtl/predictor_eval_ctrl.sv
// Predictor evaluation scheduler: stores a bit pattern, clears both
// predictors, replays the pattern one bit per cycle, scores each
// predictor's prediction against the replayed bit and reports a winner.
module predictor_eval_ctrl #(
    parameter int DEPTH = 64,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             reset,
    predictor_eval_if.slave  bus
);
    localparam int PW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [PW-1:0] fill;
    logic [AW-1:0] rd;
    logic          mem [DEPTH];

    logic          pred_clr;
    logic          act_valid;
    logic          act_bit;
    logic          done;
    logic [CW-1:0] cnt_a;
    logic [CW-1:0] cnt_b;
    logic [CW-1:0] total;
    logic [1:0]    winner;

    logic          in_idle;
    logic          full;
    logic          wr_en;
    logic [PW-1:0] fill_next;
    logic          start_ok;
    logic          last_bit;
    logic          match_a;
    logic          match_b;

    // Saturating increment; the counter sticks at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CW'(1) : v;
    endfunction

    // Decode of the IDLE-side requests; start looks at the post-write fill so
    // a bit loaded together with start is part of the run.
    always_comb begin
        in_idle   = (state == S_IDLE);
        full      = (fill == PW'(DEPTH));
        wr_en     = in_idle && bus.load_valid && !full && !bus.clear_buf;
        fill_next = fill;
        if (bus.clear_buf) begin
            fill_next = '0;
        end else if (wr_en) begin
            fill_next = fill + PW'(1);
        end
        start_ok  = in_idle && bus.start && (fill_next != '0);
        last_bit  = ({1'b0, rd} == (fill - PW'(1)));
        match_a   = (bus.pred_a == act_bit);
        match_b   = (bus.pred_b == act_bit);
    end

    // Pattern storage; contents need no reset, only fill decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[fill[AW-1:0]] <= bus.load_bit;
        end
    end

    // Scheduler FSM with all predictor-facing and result outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            fill      <= '0;
            rd        <= '0;
            pred_clr  <= 1'b0;
            act_valid <= 1'b0;
            act_bit   <= 1'b0;
            done      <= 1'b0;
            cnt_a     <= '0;
            cnt_b     <= '0;
            total     <= '0;
            winner    <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    fill <= fill_next;
                    if (start_ok) begin
                        pred_clr <= 1'b1;
                        state    <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    pred_clr  <= 1'b0;
                    cnt_a     <= '0;
                    cnt_b     <= '0;
                    total     <= '0;
                    winner    <= 2'b00;
                    rd        <= '0;
                    act_valid <= 1'b1;
                    act_bit   <= mem[0];
                    state     <= S_RUN;
                end
                S_RUN: begin
                    cnt_a <= sat_inc(cnt_a, match_a);
                    cnt_b <= sat_inc(cnt_b, match_b);
                    total <= sat_inc(total, 1'b1);
                    if (last_bit) begin
                        act_valid <= 1'b0;
                        act_bit   <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        rd      <= rd + AW'(1);
                        act_bit <= mem[rd + AW'(1)];
                    end
                end
                S_DONE: begin
                    done <= 1'b0;
                    if (cnt_a > cnt_b) begin
                        winner <= 2'b01;
                    end else if (cnt_b > cnt_a) begin
                        winner <= 2'b10;
                    end else begin
                        winner <= 2'b11;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Status outputs decoded straight from registered state and fill.
    always_comb begin
        bus.load_ready = in_idle && !full;
        bus.busy       = !in_idle;
        bus.fill       = fill;
        bus.pred_clr   = pred_clr;
        bus.act_valid  = act_valid;
        bus.act_bit    = act_bit;
        bus.cnt_a      = cnt_a;
        bus.cnt_b      = cnt_b;
        bus.total      = total;
        bus.winner     = winner;
        bus.done       = done;
        bus.state_dbg  = state;
    end
endmodule

// File: tb/tb_predictor_eval_ctrl.sv
// Bench for predictor_eval_ctrl: a DEPTH=64/CW=8 instance for the main
// sequences and a DEPTH=32/CW=4 instance for counter saturation.
module tb_predictor_eval_ctrl;
    localparam int DEPTH = 64;
    localparam int CW    = 8;
    localparam int D2    = 32;
    localparam int C2    = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    predictor_eval_if #(.DEPTH(DEPTH), .CW(CW)) bus ();
    predictor_eval_if #(.DEPTH(D2), .CW(C2)) bus2 ();

    predictor_eval_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    predictor_eval_ctrl #(.DEPTH(D2), .CW(C2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    // clock
    always #5 clk = ~clk;

    // predictor stand-ins: 0 = tied low, 1 = perfect, 2 = random, 3 = always wrong
    int   mode_a = 0;
    int   mode_b = 0;
    logic rnd_a = 1'b0;
    logic rnd_b = 1'b0;

    function automatic logic pred_of(input int mode, input logic act, input logic rnd);
        case (mode)
            0:       return 1'b0;
            1:       return act;
            2:       return rnd;
            default: return ~act;
        endcase
    endfunction

    always @(posedge clk) begin
        rnd_a <= 1'($urandom_range(0, 1));
        rnd_b <= 1'($urandom_range(0, 1));
    end

    assign bus.pred_a  = pred_of(mode_a, bus.act_bit, rnd_a);
    assign bus.pred_b  = pred_of(mode_b, bus.act_bit, rnd_b);
    assign bus2.pred_a = bus2.act_bit;
    assign bus2.pred_b = bus2.act_bit;

    // done pulse counter for the main instance
    int done_seen = 0;
    always @(negedge clk) begin
        if (bus.done) done_seen++;
    end

    // reference model: stored pattern and number of completed runs
    logic [0:0] pat_q[$];
    int         runs_exp = 0;

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    function automatic int win_of(input int a, input int b);
        if (a > b) return 1;
        if (b > a) return 2;
        return 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_one(input logic b);
        bus.load_valid = 1'b1;
        bus.load_bit   = b;
        tick();
        bus.load_valid = 1'b0;
        if (pat_q.size() < DEPTH) pat_q.push_back(b);
    endtask

    task automatic clear_pattern();
        bus.clear_buf = 1'b1;
        tick();
        bus.clear_buf = 1'b0;
        pat_q.delete();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Called one cycle after the start edge; walks CLEAR, RUN and DONE.
    task automatic run_check(input bit noise, input string tag);
        logic [0:0] exp_q[$];
        logic [0:0] b;
        int n, ea, eb;
        exp_q = pat_q;
        n  = exp_q.size();
        ea = 0;
        eb = 0;
        check({tag, " pred_clr"}, 32'(bus.pred_clr), 1);
        check({tag, " clear busy"}, 32'(bus.busy), 1);
        check({tag, " clear act_valid"}, 32'(bus.act_valid), 0);
        for (int i = 0; i < n; i++) begin
            tick();
            b = exp_q.pop_front();
            check({tag, " act_valid"}, 32'(bus.act_valid), 1);
            check({tag, " act_bit"}, 32'(bus.act_bit), 32'(b));
            check({tag, " load_ready"}, 32'(bus.load_ready), 0);
            if (bus.pred_a == b[0]) ea++;
            if (bus.pred_b == b[0]) eb++;
            if (noise) begin
                bus.start      = 1'($urandom_range(0, 1));
                bus.clear_buf  = 1'($urandom_range(0, 1));
                bus.load_valid = 1'($urandom_range(0, 1));
                bus.load_bit   = 1'($urandom_range(0, 1));
            end
        end
        bus.start      = 1'b0;
        bus.clear_buf  = 1'b0;
        bus.load_valid = 1'b0;
        tick();
        check({tag, " done"}, 32'(bus.done), 1);
        check({tag, " done act_valid"}, 32'(bus.act_valid), 0);
        check({tag, " cnt_a"}, 32'(bus.cnt_a), sat(ea, 2**CW - 1));
        check({tag, " cnt_b"}, 32'(bus.cnt_b), sat(eb, 2**CW - 1));
        check({tag, " total"}, 32'(bus.total), sat(n, 2**CW - 1));
        tick();
        runs_exp++;
        check({tag, " done low"}, 32'(bus.done), 0);
        check({tag, " busy low"}, 32'(bus.busy), 0);
        check({tag, " winner"}, 32'(bus.winner),
              win_of(sat(ea, 2**CW - 1), sat(eb, 2**CW - 1)));
        check({tag, " fill kept"}, 32'(bus.fill), n);
        check({tag, " done count"}, 32'(done_seen), runs_exp);
    endtask

    // stimulus sequence
    initial begin
        int cyc;
        int len;
        logic [7:0] t1;
        bus.clear_buf  = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_bit   = 1'b0;
        bus.start      = 1'b0;
        bus2.clear_buf  = 1'b0;
        bus2.load_valid = 1'b0;
        bus2.load_bit   = 1'b0;
        bus2.start      = 1'b0;

        // reset
        repeat (2) @(posedge clk);
        #1;
        check("reset fill", 32'(bus.fill), 0);
        check("reset busy", 32'(bus.busy), 0);
        check("reset winner", 32'(bus.winner), 0);
        check("reset cnt_a", 32'(bus.cnt_a), 0);
        check("reset act_valid", 32'(bus.act_valid), 0);
        reset = 1'b0;
        tick();
        check("idle load_ready", 32'(bus.load_ready), 1);

        // directed pattern, A perfect, B tied low
        t1 = 8'b1101_1011;
        for (int i = 7; i >= 0; i--) load_one(t1[i]);
        check("t1 fill", 32'(bus.fill), 8);
        mode_a = 1;
        mode_b = 0;
        pulse_start();
        run_check(1'b0, "t1");
        check("t1 cnt_a const", 32'(bus.cnt_a), 8);
        check("t1 cnt_b const", 32'(bus.cnt_b), 2);
        check("t1 winner const", 32'(bus.winner), 1);

        // empty buffer start ignored, then start with a same-cycle load
        clear_pattern();
        pulse_start();
        check("empty pred_clr", 32'(bus.pred_clr), 0);
        check("empty busy", 32'(bus.busy), 0);
        tick();
        check("empty busy later", 32'(bus.busy), 0);
        bus.start      = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_bit   = 1'b1;
        tick();
        bus.start      = 1'b0;
        bus.load_valid = 1'b0;
        pat_q.push_back(1'b1);
        run_check(1'b0, "t2");

        // full buffer, extra load dropped
        clear_pattern();
        for (int i = 0; i < DEPTH; i++) load_one(1'($urandom_range(0, 1)));
        check("t3 load_ready full", 32'(bus.load_ready), 0);
        check("t3 fill full", 32'(bus.fill), DEPTH);
        load_one(1'b1);
        check("t3 fill after drop", 32'(bus.fill), DEPTH);
        mode_a = 2;
        mode_b = 2;
        pulse_start();
        run_check(1'b0, "t3");

        // saturation on the narrow instance
        for (int i = 0; i < 20; i++) begin
            bus2.load_valid = 1'b1;
            bus2.load_bit   = 1'($urandom_range(0, 1));
            tick();
        end
        bus2.load_valid = 1'b0;
        check("t4 fill", 32'(bus2.fill), 20);
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        cyc = 0;
        while (!bus2.done && cyc < 100) begin
            tick();
            cyc++;
        end
        check("t4 done seen", 32'(bus2.done), 1);
        check("t4 done latency", 32'(cyc), 21);
        check("t4 cnt_a", 32'(bus2.cnt_a), sat(20, 2**C2 - 1));
        check("t4 cnt_b", 32'(bus2.cnt_b), sat(20, 2**C2 - 1));
        check("t4 total", 32'(bus2.total), sat(20, 2**C2 - 1));
        tick();
        check("t4 winner", 32'(bus2.winner), 3);

        // inputs ignored during a run, then identical replay
        clear_pattern();
        for (int i = 0; i < 12; i++) load_one(1'($urandom_range(0, 1)));
        mode_a = 1;
        mode_b = 0;
        pulse_start();
        run_check(1'b1, "t6 first");
        pulse_start();
        run_check(1'b0, "t6 replay");

        // randomized runs
        for (int r = 0; r < 4; r++) begin
            clear_pattern();
            len = $urandom_range(1, DEPTH);
            for (int i = 0; i < len; i++) load_one(1'($urandom_range(0, 1)));
            mode_a = $urandom_range(0, 3);
            mode_b = $urandom_range(0, 3);
            pulse_start();
            run_check(1'($urandom_range(0, 1)), "rand");
        end

        // reset in the third RUN cycle aborts the run
        clear_pattern();
        for (int i = 0; i < 10; i++) load_one(1'($urandom_range(0, 1)));
        mode_a = 2;
        mode_b = 1;
        pulse_start();
        repeat (3) tick();
        check("t5 running", 32'(bus.act_valid), 1);
        #1;
        reset = 1'b1;
        #1;
        check("t5 act_valid", 32'(bus.act_valid), 0);
        check("t5 busy", 32'(bus.busy), 0);
        check("t5 cnt_a", 32'(bus.cnt_a), 0);
        check("t5 cnt_b", 32'(bus.cnt_b), 0);
        check("t5 total", 32'(bus.total), 0);
        check("t5 fill", 32'(bus.fill), 0);
        repeat (3) tick();
        reset = 1'b0;
        pat_q.delete();
        tick();
        check("t5 no done", 32'(done_seen), runs_exp);
        pulse_start();
        check("t5 start ignored", 32'(bus.pred_clr), 0);
        check("t5 busy after start", 32'(bus.busy), 0);
        tick();
        check("t5 still idle", 32'(bus.busy), 0);

        // report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
